// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: select codes, FSM states, default vector.
package pc_sequencer_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
    localparam logic [1:0] PC_SEL_EXC    = 2'b11;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHandler
    } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC target: sequential, jump (page-relative) or branch (PC-relative).
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_BYTES = 2
) (
    input  logic [31:0] pc,
    input  logic [1:0]  to_pc_sel,
    input  logic [31:0] branch_off,
    input  logic [11:0] jump_lo,
    output logic [31:0] pc_plus,
    output logic [31:0] pc_target
);

    always_comb begin
        pc_plus = pc + 32'(INSTR_BYTES);
        case (to_pc_sel)
            PC_SEL_JUMP:   pc_target = {pc_plus[31:12], jump_lo};
            PC_SEL_BRANCH: pc_target = pc_plus + branch_off;
            // The exception code never uses this target; sequential is a harmless filler.
            default:       pc_target = pc_plus;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC selection and overflow-exception sequencing (RUN/FLUSH/HANDLER).
// Optional retired-advance counter enabled by defining PC_SEQ_INSTRET_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned INSTR_BYTES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  to_pc_sel,
    input  logic        stall,
    input  logic [31:0] branch_off,
    input  logic [11:0] jump_lo,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        flush,
    output logic        in_exception,
    output logic        double_fault,
    output logic [31:0] instret
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q, flush_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        double_fault_q, double_fault_d;

    logic [31:0] pc_plus;
    logic [31:0] pc_target;

    pc_next_calc #(
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_next_calc (
        .pc         (pc_q),
        .to_pc_sel  (to_pc_sel),
        .branch_off (branch_off),
        .jump_lo    (jump_lo),
        .pc_plus    (pc_plus),
        .pc_target  (pc_target)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        epc_d          = epc_q;
        flush_d        = flush_q;
        flush_cnt_d    = flush_cnt_q;
        double_fault_d = double_fault_q;

        case (state_q)
            StRun: begin
                if (to_pc_sel == PC_SEL_EXC) begin
                    epc_d       = exc_pc;
                    pc_d        = EXC_VECTOR;
                    flush_d     = 1'b1;
                    flush_cnt_d = FlushLoad;
                    state_d     = StFlush;
                end else if (!stall) begin
                    pc_d = pc_target;
                end
            end

            StFlush: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = StHandler;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end

            StHandler: begin
                // A fault inside the handler beats a simultaneous eret; epc keeps the first fault.
                if (to_pc_sel == PC_SEL_EXC) begin
                    double_fault_d = 1'b1;
                    pc_d           = EXC_VECTOR;
                    flush_d        = 1'b1;
                    flush_cnt_d    = FlushLoad;
                    state_d        = StFlush;
                end else if (eret && !stall) begin
                    pc_d    = epc_q;
                    state_d = StRun;
                end else if (!stall) begin
                    pc_d = pc_target;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StRun;
            pc_q           <= RESET_PC;
            epc_q          <= 32'h0;
            flush_q        <= 1'b0;
            flush_cnt_q    <= 4'd0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            epc_q          <= epc_d;
            flush_q        <= flush_d;
            flush_cnt_q    <= flush_cnt_d;
            double_fault_q <= double_fault_d;
        end
    end

`ifdef PC_SEQ_INSTRET_EN
    logic        advance;
    logic [31:0] instret_q, instret_d;

    // Counts only normal sequential/jump/branch loads, never exception entry or eret.
    always_comb begin
        advance   = !stall && (to_pc_sel != PC_SEL_EXC) &&
                    ((state_q == StRun) || ((state_q == StHandler) && !eret));
        instret_d = advance ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'h0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'h0;
`endif

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign flush        = flush_q;
    assign in_exception = (state_q != StRun);
    assign double_fault = double_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (expected values computed by hand).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  to_pc_sel;
    logic        stall;
    logic [31:0] branch_off;
    logic [11:0] jump_lo;
    logic [31:0] exc_pc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flush;
    logic        in_exception;
    logic        double_fault;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int adv    = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .to_pc_sel    (to_pc_sel),
        .stall        (stall),
        .branch_off   (branch_off),
        .jump_lo      (jump_lo),
        .exc_pc       (exc_pc),
        .eret         (eret),
        .pc           (pc),
        .epc          (epc),
        .flush        (flush),
        .in_exception (in_exception),
        .double_fault (double_fault),
        .instret      (instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [1:0] sel, input logic stl, input logic er);
        to_pc_sel = sel;
        stall     = stl;
        eret      = er;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_instret(input int n);
`ifdef PC_SEQ_INSTRET_EN
        return 32'(n);
`else
        return 32'h0 + 32'(n * 0);
`endif
    endfunction

    initial begin
        reset = 1'b1;
        to_pc_sel = 2'b00; stall = 1'b0; eret = 1'b0;
        branch_off = 32'h0; jump_lo = 12'h0; exc_pc = 32'h0;
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        check("reset_pc", pc, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_flush", 32'(flush), 32'h0);
        check("reset_in_exc", 32'(in_exception), 32'h0);
        check("reset_dfault", 32'(double_fault), 32'h0);
        check("reset_instret", instret, 32'h0);
        reset = 1'b0;

        step(2'b00, 1'b0, 1'b0); check("seq1", pc, 32'h2);
        step(2'b00, 1'b0, 1'b0); check("seq2", pc, 32'h4);
        step(2'b00, 1'b0, 1'b0); check("seq3", pc, 32'h6);
        adv = 3;
        check("instret_seq", instret, exp_instret(adv));

        jump_lo = 12'hFFE;
        step(2'b01, 1'b0, 1'b0); check("jump_low", pc, 32'h0000_0FFE);
        branch_off = 32'h0000_0FFE;
        step(2'b10, 1'b0, 1'b0); check("branch_fwd", pc, 32'h0000_1FFE);
        jump_lo = 12'h0A4;
        step(2'b01, 1'b0, 1'b0); check("jump_page", pc, 32'h0000_20A4);
        branch_off = 32'hFFFF_E05A;
        step(2'b10, 1'b0, 1'b0); check("branch_back", pc, 32'h0000_0100);
        branch_off = 32'hFFFF_FFF0;
        step(2'b10, 1'b1, 1'b0); check("branch_stall", pc, 32'h0000_0100);
        step(2'b10, 1'b0, 1'b0); check("branch_neg", pc, 32'h0000_00F2);
        jump_lo = 12'h040;
        step(2'b01, 1'b0, 1'b0); check("jump_40", pc, 32'h0000_0040);
        adv = 9;
        check("instret_mix", instret, exp_instret(adv));

        // Exception from RUN wins over stall.
        exc_pc = 32'h0000_003E;
        step(2'b11, 1'b1, 1'b0);
        check("exc_pc_vec", pc, 32'h0000_0100);
        check("exc_epc", epc, 32'h0000_003E);
        check("exc_flush1", 32'(flush), 32'h1);
        check("exc_in_exc", 32'(in_exception), 32'h1);
        check("exc_instret", instret, exp_instret(adv));
        exc_pc = 32'h0000_0999;
        step(2'b11, 1'b0, 1'b1);
        check("flush2", 32'(flush), 32'h1);
        check("flush2_pc", pc, 32'h0000_0100);
        step(2'b10, 1'b0, 1'b1);
        check("flush_end", 32'(flush), 32'h0);
        check("handler_in_exc", 32'(in_exception), 32'h1);
        check("handler_pc", pc, 32'h0000_0100);
        check("flush_epc_kept", epc, 32'h0000_003E);

        step(2'b00, 1'b0, 1'b0); check("handler_seq", pc, 32'h0000_0102);
        adv = 10;
        check("instret_handler", instret, exp_instret(adv));
        step(2'b00, 1'b1, 1'b1);
        check("eret_stalled_pc", pc, 32'h0000_0102);
        check("eret_stalled_exc", 32'(in_exception), 32'h1);
        step(2'b00, 1'b0, 1'b1);
        check("eret_pc", pc, 32'h0000_003E);
        check("eret_in_exc", 32'(in_exception), 32'h0);
        check("eret_instret", instret, exp_instret(adv));
        step(2'b00, 1'b0, 1'b1);
        check("run_eret_ignored", pc, 32'h0000_0040);
        adv = 11;

        // Second exception, then a fault with eret inside the handler.
        exc_pc = 32'h0000_0200;
        step(2'b11, 1'b0, 1'b0);
        check("exc2_epc", epc, 32'h0000_0200);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        check("exc2_handler_flush", 32'(flush), 32'h0);
        exc_pc = 32'h0000_0777;
        step(2'b11, 1'b0, 1'b1);
        check("dfault_set", 32'(double_fault), 32'h1);
        check("dfault_pc", pc, 32'h0000_0100);
        check("dfault_epc", epc, 32'h0000_0200);
        check("dfault_flush", 32'(flush), 32'h1);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        check("dfault_eret_pc", pc, 32'h0000_0200);
        check("dfault_sticky", 32'(double_fault), 32'h1);
        check("instret_dfault", instret, exp_instret(adv));

        reset = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        check("dfault_cleared", 32'(double_fault), 32'h0);
        reset = 1'b0;

        // Reset asserted during the second FLUSH cycle.
        exc_pc = 32'h0000_0050;
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        check("pre_reset_flush", 32'(flush), 32'h1);
        reset = 1'b1;
        step(2'b11, 1'b0, 1'b1);
        check("midflush_pc", pc, 32'h0);
        check("midflush_flush", 32'(flush), 32'h0);
        check("midflush_in_exc", 32'(in_exception), 32'h0);
        check("midflush_epc", epc, 32'h0);
        check("midflush_instret", instret, 32'h0);
        reset = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        check("post_reset_seq", pc, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumes the 2-bit PC-select code produced by the priority encoder: 00 sequential, 01 jump, 10 branch, 11 invalid/overflow.
- Owns the architectural PC register, computes and applies the next PC, and handles the overflow exception.
- The exception path is sequenced as: save EPC, vector to the handler, flush the pipeline, run the handler, return on eret.
- Sits between the fetch stage and the control/ALU stages of the 16-bit-instruction datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0100, handler entry address for overflow/invalid.
- INSTR_BYTES, 2, sequential increment in bytes.
- FLUSH_CYCLES, 2, number of cycles `flush` is held after an exception is taken (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- to_pc_sel  input  2  PC-select code from the priority encoder.
- stall  input  1  hazard stall; holds the PC.
- branch_off  input  32  branch offset, already sign-extended and shifted left by 1.
- jump_lo  input  12  jump low bits, already shifted left by 1.
- exc_pc  input  32  PC of the instruction that faulted.
- eret  input  1  return-from-exception strobe.
- pc  output  32  current PC.
- epc  output  32  saved exception PC.
- flush  output  1  pipeline flush request.
- in_exception  output  1  high while in the FLUSH or HANDLER state.
- double_fault  output  1  sticky flag for an exception raised inside the handler.
- instret  output  32  retired-advance counter (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, epc=0, flush=0, in_exception=0, double_fault=0, instret=0, state=RUN. Reset overrides all other inputs, including mid-FLUSH and mid-HANDLER.
- pc_plus = pc + INSTR_BYTES (32-bit, wraps modulo 2^32).
- Next-PC per select code:
  - 00: pc_plus.
  - 01: {pc_plus[31:12], jump_lo}.
  - 10: pc_plus + branch_off (32-bit add, overflow ignored).
- All PC updates are registered: 1-cycle latency from inputs to `pc`.
- RUN state:
  - Select 11: epc<=exc_pc, pc<=EXC_VECTOR, flush<=1, flush counter loaded, state->FLUSH. Select 11 wins over stall.
  - Otherwise, if stall=1: pc holds.
  - Otherwise: pc<=next-PC.
  - eret is ignored in RUN.
- FLUSH state:
  - pc holds at EXC_VECTOR; flush=1 for exactly FLUSH_CYCLES cycles; in_exception=1.
  - All of to_pc_sel, stall and eret are ignored.
  - When the counter expires: flush<=0, state->HANDLER.
- HANDLER state:
  - Sequencing is as in RUN; in_exception=1.
  - eret=1 with stall=0: pc<=epc, state->RUN, in_exception<=0.
  - eret=1 with stall=1: eret is held off and must be re-asserted by the source.
  - Select 11: double_fault<=1 (sticky until reset), pc<=EXC_VECTOR, epc unchanged, state->FLUSH.
  - Select 11 and eret in the same cycle: the fault wins.
- epc changes only when an exception is taken from RUN.

Optional Feature:
- Macro: PC_SEQ_INSTRET_EN.
- Defined: instret increments by 1 on every cycle in which pc is loaded from the sequential, jump or branch path (RUN or HANDLER, stall=0). It does not increment on exception entry or eret, and wraps modulo 2^32.
- Undefined: the counter logic is compiled out and instret is tied to 0.

Decomposition:
- Shared package holds:
  - PC-select code constants PC_SEL_SEQ=2'b00, PC_SEL_JUMP=2'b01, PC_SEL_BRANCH=2'b10, PC_SEL_EXC=2'b11.
  - State enum: RUN, FLUSH, HANDLER.
  - Default EXC_VECTOR constant.
- One sub-module, pc_next_calc: purely combinational; computes pc_plus and the select-code target. The sequencer FSM instantiates it.

Test Plan:
- Reset with RESET_PC=0, then select=00 for 3 cycles, stall=0 -> pc = 0x2, 0x4, 0x6; instret=3 with the macro defined.
- pc=0x0000_1FFE, select=01, jump_lo=0x0A4 -> pc=0x0000_20A4 (upper 20 bits taken from pc_plus=0x2000).
- pc=0x100, select=10, branch_off=0xFFFF_FFF0 -> pc=0xF2. Repeat with stall=1 -> pc holds at 0x100.
- pc=0x40, select=11, exc_pc=0x3E, stall=1 -> next cycle: pc=0x100, epc=0x3E, flush high for exactly 2 cycles, then HANDLER. An eret with stall=0 in HANDLER -> pc=0x3E, in_exception=0.
- In HANDLER, drive select=11 and eret together -> double_fault=1, pc=0x100, epc unchanged. double_fault stays 1 through a later eret and clears only on reset.
- Assert reset during the second FLUSH cycle -> next cycle: pc=RESET_PC, flush=0, in_exception=0, epc=0.
